// File: rtl/lcd_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bus_sequencer
// Purpose  : Avalon-MM slave that converts single read/write transfers into
//            timed HD44780 bus cycles (setup, enable pulse, hold, recovery).
//            After LCD writes it can optionally poll the busy flag (DB7)
//            before acknowledging the transfer.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   address[1:0] in   bit0 = RW (1 = LCD read), bit1 = RS (1 = data reg)
//   read         in   Avalon read request
//   write        in   Avalon write request (wins over read)
//   writedata    in   byte written to the LCD
//   readdata     out  byte read from the LCD, valid in the ack cycle
//   waitrequest  out  Avalon stall
//   lcd_timeout  out  sticky: last write's busy poll hit POLL_MAX
//   LCD_E        out  LCD enable strobe
//   LCD_RS       out  LCD register select
//   LCD_RW       out  LCD read/not-write
//   LCD_data     io   LCD data bus, driven only during write cycles
// ============================================================================
module lcd_bus_sequencer #(
    parameter int T_AS      = 3,
    parameter int T_EH      = 12,
    parameter int T_AH      = 1,
    parameter int T_REC     = 9,
    parameter int BUSY_POLL = 1,
    parameter int POLL_MAX  = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] address,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       waitrequest,
    output logic       lcd_timeout,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    inout  wire  [7:0] LCD_data
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_TMAX_A = (T_AS > T_EH) ? T_AS : T_EH;
    localparam int c_TMAX_B = (T_AH > T_REC) ? T_AH : T_REC;
    localparam int c_TMAX   = (c_TMAX_A > c_TMAX_B) ? c_TMAX_A : c_TMAX_B;
    // The phase counter only ever holds T-1, so clog2(T) bits suffice.
    localparam int c_CNT_W  = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;
    // Wide enough to hold POLL_MAX itself, so the count never wraps.
    localparam int c_POLL_W = $clog2(POLL_MAX + 1);

    localparam logic [c_CNT_W-1:0]  c_LD_AS    = c_CNT_W'(T_AS - 1);
    localparam logic [c_CNT_W-1:0]  c_LD_EH    = c_CNT_W'(T_EH - 1);
    localparam logic [c_CNT_W-1:0]  c_LD_AH    = c_CNT_W'(T_AH - 1);
    localparam logic [c_CNT_W-1:0]  c_LD_REC   = c_CNT_W'(T_REC - 1);
    localparam logic [c_POLL_W-1:0] c_POLL_MAX = c_POLL_W'(POLL_MAX);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_SETUP   = 3'd1;
    localparam logic [2:0] c_ENABLE  = 3'd2;
    localparam logic [2:0] c_HOLD    = 3'd3;
    localparam logic [2:0] c_RECOVER = 3'd4;
    localparam logic [2:0] c_ACK     = 3'd5;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_is_write;
    logic                r_polling;
    logic [7:0]          r_wdata;
    logic [c_POLL_W-1:0] r_poll_cnt;
    logic [7:0]          r_readdata;
    logic                r_timeout;
    logic                r_ack;
    logic                r_lcd_e;
    logic                r_rs;
    logic                r_rw;
    logic                r_drive;

    // ------------------------------------------------------------------
    // Combinational next-state logic
    // ------------------------------------------------------------------
    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_load;
    logic               w_accept;
    logic               w_mismatch;
    logic               w_last;
    logic               w_start_poll;
    logic               w_set_timeout;
    logic               w_rs_nxt;
    logic               w_rw_nxt;
    logic               w_bus_phase_nxt;

    assign w_accept   = (r_state == c_IDLE) && (read || write);
    // A write must target RW=0 and a read RW=1; anything else is refused
    // without touching the panel.
    assign w_mismatch = write ? address[0] : ~address[0];
    assign w_last     = (r_cnt == '0);

    always_comb begin
        w_state_nxt   = r_state;
        w_start_poll  = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (read || write) begin
                    w_state_nxt = w_mismatch ? c_ACK : c_SETUP;
                end
            end
            c_SETUP: begin
                if (w_last) w_state_nxt = c_ENABLE;
            end
            c_ENABLE: begin
                if (w_last) w_state_nxt = c_HOLD;
            end
            c_HOLD: begin
                if (w_last) w_state_nxt = c_RECOVER;
            end
            c_RECOVER: begin
                if (w_last) begin
                    if (!r_is_write || (BUSY_POLL == 0)) begin
                        w_state_nxt = c_ACK;
                    end else if (!r_polling) begin
                        // The data write just finished: start the first status read.
                        w_state_nxt  = c_SETUP;
                        w_start_poll = 1'b1;
                    end else if (!r_readdata[7]) begin
                        w_state_nxt = c_ACK;
                    end else if (r_poll_cnt == c_POLL_MAX) begin
                        w_state_nxt   = c_ACK;
                        w_set_timeout = 1'b1;
                    end else begin
                        w_state_nxt  = c_SETUP;
                        w_start_poll = 1'b1;
                    end
                end
            end
            c_ACK: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Phase length loaded into the down-counter on entry to each state.
    always_comb begin
        w_cnt_load = '0;
        case (w_state_nxt)
            c_SETUP:   w_cnt_load = c_LD_AS;
            c_ENABLE:  w_cnt_load = c_LD_EH;
            c_HOLD:    w_cnt_load = c_LD_AH;
            c_RECOVER: w_cnt_load = c_LD_REC;
            default:   w_cnt_load = '0;
        endcase
    end

    // RS/RW follow the latched address for the access itself, switch to a
    // status read (RS=0, RW=1) for busy polls, and park at RS=0/RW=1 on ack
    // so the panel never sees a write strobe configuration while idle.
    always_comb begin
        w_rs_nxt = r_rs;
        w_rw_nxt = r_rw;
        if (w_accept && !w_mismatch) begin
            w_rs_nxt = address[1];
            w_rw_nxt = address[0];
        end else if (w_start_poll) begin
            w_rs_nxt = 1'b0;
            w_rw_nxt = 1'b1;
        end else if (w_state_nxt == c_ACK) begin
            w_rs_nxt = 1'b0;
            w_rw_nxt = 1'b1;
        end
    end

    assign w_bus_phase_nxt = (w_state_nxt == c_SETUP) ||
                             (w_state_nxt == c_ENABLE) ||
                             (w_state_nxt == c_HOLD);

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_is_write <= 1'b0;
            r_polling  <= 1'b0;
            r_wdata    <= 8'h00;
            r_poll_cnt <= '0;
            r_readdata <= 8'h00;
            r_timeout  <= 1'b0;
            r_ack      <= 1'b0;
            r_lcd_e    <= 1'b0;
            r_rs       <= 1'b0;
            r_rw       <= 1'b1;
            r_drive    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_state_nxt != r_state) begin
                r_cnt <= w_cnt_load;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end

            if (w_accept) begin
                r_is_write <= write;
                r_polling  <= 1'b0;
                r_wdata    <= writedata;
                r_poll_cnt <= '0;
                // Refused accesses and plain writes report 0x00.
                r_readdata <= 8'h00;
                if (write && !w_mismatch) begin
                    r_timeout <= 1'b0;
                end
            end

            // Only reached while r_poll_cnt < POLL_MAX, so no saturation needed.
            if (w_start_poll) begin
                r_polling  <= 1'b1;
                r_poll_cnt <= r_poll_cnt + c_POLL_W'(1);
            end

            // Capture the panel's byte on the last enable cycle of any read
            // (user read or status poll); the panel drives only while E is high.
            if ((r_state == c_ENABLE) && w_last && r_rw) begin
                r_readdata <= LCD_data;
            end

            if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end

            // Bus-facing strobes are registered from the next state so they
            // change cleanly on the clock edge and clear asynchronously on reset.
            r_ack   <= (w_state_nxt == c_ACK);
            r_lcd_e <= (w_state_nxt == c_ENABLE);
            r_rs    <= w_rs_nxt;
            r_rw    <= w_rw_nxt;
            r_drive <= w_bus_phase_nxt && !w_rw_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign waitrequest = (read || write) && !r_ack;
    assign readdata    = r_readdata;
    assign lcd_timeout = r_timeout;
    assign LCD_E       = r_lcd_e;
    assign LCD_RS      = r_rs;
    assign LCD_RW      = r_rw;
    assign LCD_data    = r_drive ? r_wdata : 8'hzz;

endmodule
`default_nettype wire

// File: tb/tb_lcd_bus_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_bus_sequencer
// Purpose  : Directed testbench for lcd_bus_sequencer. Three instances:
//            u0 without busy polling, u1 with default polling, u2 with
//            POLL_MAX=4. Each has a small behavioural LCD that drives its
//            bus while E=1 and RW=1. The u0 bus is pulled up, so a released
//            bus reads back as 0xFF.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_bus_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- u0 : BUSY_POLL = 0 ----------------
    logic [1:0] u0_addr = 2'b00;
    logic       u0_rd = 1'b0, u0_wr = 1'b0;
    logic [7:0] u0_wdata = 8'h00;
    logic [7:0] u0_rdata;
    logic       u0_wait, u0_to, u0_e, u0_rs, u0_rw;
    wire  [7:0] u0_data;

    lcd_bus_sequencer #(.BUSY_POLL(0)) u0 (
        .clk(clk), .reset(reset), .address(u0_addr), .read(u0_rd),
        .write(u0_wr), .writedata(u0_wdata), .readdata(u0_rdata),
        .waitrequest(u0_wait), .lcd_timeout(u0_to), .LCD_E(u0_e),
        .LCD_RS(u0_rs), .LCD_RW(u0_rw), .LCD_data(u0_data)
    );
    assign u0_data = (u0_e && u0_rw) ? 8'h80 : 8'hzz;
    for (genvar gi = 0; gi < 8; gi++) begin : g_pu0
        pullup (u0_data[gi]);
    end

    // ---------------- u1 : BUSY_POLL = 1, POLL_MAX = 1000 ----------------
    logic [1:0] u1_addr = 2'b00;
    logic       u1_rd = 1'b0, u1_wr = 1'b0;
    logic [7:0] u1_wdata = 8'h00;
    logic [7:0] u1_rdata;
    logic       u1_wait, u1_to, u1_e, u1_rs, u1_rw;
    wire  [7:0] u1_data;
    int         n1 = 0;

    lcd_bus_sequencer u1 (
        .clk(clk), .reset(reset), .address(u1_addr), .read(u1_rd),
        .write(u1_wr), .writedata(u1_wdata), .readdata(u1_rdata),
        .waitrequest(u1_wait), .lcd_timeout(u1_to), .LCD_E(u1_e),
        .LCD_RS(u1_rs), .LCD_RW(u1_rw), .LCD_data(u1_data)
    );
    // Busy for the first two reads, ready afterwards.
    always @(negedge u1_e) if (u1_rw) n1 <= n1 + 1;
    assign u1_data = (u1_e && u1_rw) ? ((n1 < 2) ? 8'h80 : 8'h00) : 8'hzz;

    // ---------------- u2 : BUSY_POLL = 1, POLL_MAX = 4 ----------------
    logic [1:0] u2_addr = 2'b00;
    logic       u2_rd = 1'b0, u2_wr = 1'b0;
    logic [7:0] u2_wdata = 8'h00;
    logic [7:0] u2_rdata;
    logic       u2_wait, u2_to, u2_e, u2_rs, u2_rw;
    wire  [7:0] u2_data;
    int         n2 = 0;

    lcd_bus_sequencer #(.POLL_MAX(4)) u2 (
        .clk(clk), .reset(reset), .address(u2_addr), .read(u2_rd),
        .write(u2_wr), .writedata(u2_wdata), .readdata(u2_rdata),
        .waitrequest(u2_wait), .lcd_timeout(u2_to), .LCD_E(u2_e),
        .LCD_RS(u2_rs), .LCD_RW(u2_rw), .LCD_data(u2_data)
    );
    // Permanently busy panel.
    always @(negedge u2_e) if (u2_rw) n2 <= n2 + 1;
    assign u2_data = (u2_e && u2_rw) ? 8'h80 : 8'hzz;

    // ---------------- check helpers ----------------
    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        total++;
        assert (obs == exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int ackc;

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        chkb("rst_e", u0_e, 1'b0);
        chkb("rst_rs", u0_rs, 1'b0);
        chkb("rst_rw", u0_rw, 1'b1);
        chk8("rst_data", u0_data, 8'hFF);
        chk8("rst_rdata", u0_rdata, 8'h00);
        chkb("rst_to", u0_to, 1'b0);
        chkb("rst_wait", u0_wait, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        // ---------------- A: data write 0x41, no polling ----------------
        u0_addr = 2'b10; u0_wdata = 8'h41; u0_wr = 1'b1;
        for (int k = 0; k <= 26; k++) begin
            @(negedge clk);
            chkb($sformatf("A_e_c%0d", k), u0_e, (k >= 4 && k <= 15));
            chkb($sformatf("A_wait_c%0d", k), u0_wait, (k != 26));
            chk8($sformatf("A_data_c%0d", k), u0_data, (k >= 1 && k <= 16) ? 8'h41 : 8'hFF);
            if (k >= 1 && k <= 16) begin
                chkb($sformatf("A_rs_c%0d", k), u0_rs, 1'b1);
                chkb($sformatf("A_rw_c%0d", k), u0_rw, 1'b0);
            end
            tick();
        end
        u0_wr = 1'b0;
        tick();

        // ---------------- B: status read, panel returns 0x80 ----------------
        u0_addr = 2'b01; u0_rd = 1'b1;
        for (int k = 0; k <= 26; k++) begin
            @(negedge clk);
            chkb($sformatf("B_e_c%0d", k), u0_e, (k >= 4 && k <= 15));
            chkb($sformatf("B_wait_c%0d", k), u0_wait, (k != 26));
            chk8($sformatf("B_data_c%0d", k), u0_data, (k >= 4 && k <= 15) ? 8'h80 : 8'hFF);
            if (k >= 1 && k <= 16) begin
                chkb($sformatf("B_rs_c%0d", k), u0_rs, 1'b0);
                chkb($sformatf("B_rw_c%0d", k), u0_rw, 1'b1);
            end
            if (k == 26) chk8("B_rdata", u0_rdata, 8'h80);
            tick();
        end
        u0_rd = 1'b0;
        tick();

        // ---------------- E1: mismatched read (RW=0) ----------------
        u0_addr = 2'b00; u0_rd = 1'b1;
        for (int k = 0; k <= 1; k++) begin
            @(negedge clk);
            chkb($sformatf("E1_wait_c%0d", k), u0_wait, (k == 0));
            chkb($sformatf("E1_e_c%0d", k), u0_e, 1'b0);
            if (k == 1) chk8("E1_rdata", u0_rdata, 8'h00);
            tick();
        end
        u0_rd = 1'b0;
        tick();

        // ---------------- E2: mismatched write (RW=1) ----------------
        u0_addr = 2'b01; u0_wdata = 8'hA5; u0_wr = 1'b1;
        for (int k = 0; k <= 1; k++) begin
            @(negedge clk);
            chkb($sformatf("E2_wait_c%0d", k), u0_wait, (k == 0));
            chkb($sformatf("E2_e_c%0d", k), u0_e, 1'b0);
            chk8($sformatf("E2_data_c%0d", k), u0_data, 8'hFF);
            if (k == 1) chk8("E2_rdata", u0_rdata, 8'h00);
            tick();
        end
        u0_wr = 1'b0;
        @(negedge clk);
        chkb("E2_e_after", u0_e, 1'b0);
        tick();

        // ---------------- C: write with busy poll, ready on 3rd read ----------------
        u1_addr = 2'b00; u1_wdata = 8'h01; u1_wr = 1'b1;
        ackc = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 30) begin
                chkb("C_poll_e", u1_e, 1'b1);
                chkb("C_poll_rs", u1_rs, 1'b0);
                chkb("C_poll_rw", u1_rw, 1'b1);
            end
            if (!u1_wait) begin
                ackc = k;
                break;
            end
            tick();
        end
        chki("C_ack_cycle", ackc, 101);
        chk8("C_rdata", u1_rdata, 8'h00);
        chkb("C_timeout", u1_to, 1'b0);
        chki("C_status_reads", n1, 3);
        tick();
        u1_wr = 1'b0;
        tick();

        // ---------------- C2: reads never poll ----------------
        u1_addr = 2'b11; u1_rd = 1'b1;
        ackc = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!u1_wait) begin
                ackc = k;
                break;
            end
            tick();
        end
        chki("C2_ack_cycle", ackc, 26);
        chki("C2_reads", n1, 4);
        tick();
        u1_rd = 1'b0;
        tick();

        // ---------------- D: poll timeout with POLL_MAX=4 ----------------
        u2_addr = 2'b00; u2_wdata = 8'h01; u2_wr = 1'b1;
        ackc = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 125) chkb("D_to_before_ack", u2_to, 1'b0);
            if (!u2_wait) begin
                ackc = k;
                break;
            end
            tick();
        end
        chki("D_ack_cycle", ackc, 126);
        chki("D_status_reads", n2, 4);
        chk8("D_rdata", u2_rdata, 8'h80);
        chkb("D_timeout_set", u2_to, 1'b1);
        tick();
        u2_wr = 1'b0;
        tick();

        // Mismatched write is not a matched write: flag stays set.
        u2_addr = 2'b01; u2_wr = 1'b1;
        for (int k = 0; k <= 1; k++) begin
            @(negedge clk);
            chkb($sformatf("D2_wait_c%0d", k), u2_wait, (k == 0));
            chkb($sformatf("D2_to_c%0d", k), u2_to, 1'b1);
            tick();
        end
        u2_wr = 1'b0;
        tick();

        // Next matched write clears the flag at its start, then times out again.
        u2_addr = 2'b10; u2_wdata = 8'h55; u2_wr = 1'b1;
        ackc = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 1) chkb("D3_to_cleared", u2_to, 1'b0);
            if (!u2_wait) begin
                ackc = k;
                break;
            end
            tick();
        end
        chki("D3_ack_cycle", ackc, 126);
        chki("D3_status_reads", n2, 8);
        chkb("D3_timeout_set", u2_to, 1'b1);
        tick();
        u2_wr = 1'b0;
        tick();

        // ---------------- F: reset during ENABLE of a write ----------------
        u0_addr = 2'b00; u0_wdata = 8'h38; u0_wr = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chkb("F_e_pre", u0_e, 1'b1);
        chk8("F_data_pre", u0_data, 8'h38);
        #2 reset = 1'b1;
        #1;
        chkb("F_e_async", u0_e, 1'b0);
        chk8("F_data_async", u0_data, 8'hFF);
        chkb("F_wait_async", u0_wait, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chkb($sformatf("F_wait_rst%0d", k), u0_wait, 1'b1);
            chkb($sformatf("F_e_rst%0d", k), u0_e, 1'b0);
        end
        tick();
        reset = 1'b0;
        // Master keeps the write asserted; this cycle is cycle 0 of the reissue.
        for (int k = 0; k <= 26; k++) begin
            @(negedge clk);
            chkb($sformatf("F_e_c%0d", k), u0_e, (k >= 4 && k <= 15));
            chkb($sformatf("F_wait_c%0d", k), u0_wait, (k != 26));
            chk8($sformatf("F_data_c%0d", k), u0_data, (k >= 1 && k <= 16) ? 8'h38 : 8'hFF);
            tick();
        end
        u0_wr = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_bus_sequencer.md
# lcd_bus_sequencer

Timing engine between the Avalon-MM system interconnect and an HD44780-compatible character LCD. It turns single Avalon read/write transfers into correctly timed LCD bus cycles: address setup, enable pulse, hold and recovery. After instruction/data writes it can optionally poll the busy flag before completing the transfer. Software sees one stalled transfer per LCD access and never hand-times the panel.

## Interface
- T_AS, 3: RS/RW/data setup cycles before LCD_E rises (≥1)
- T_EH, 12: LCD_E high cycles (≥1)
- T_AH, 1: hold cycles after LCD_E falls, with RS/RW/data still driven (≥1)
- T_REC, 9: recovery cycles after hold, before the next LCD cycle or ack (≥1)
- BUSY_POLL, 1: 1 = after every LCD write, poll the status register until DB7=0
- POLL_MAX, 1000: maximum number of status reads per write before giving up (≥1)

Ports:
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- address  in  2  bit0 selects RW (1 = LCD read), bit1 selects RS (1 = data register)
- read  in  1  Avalon read request
- write  in  1  Avalon write request
- writedata  in  8  byte to the LCD
- readdata  out  8  byte from the LCD, valid in the ack cycle
- waitrequest  out  1  Avalon stall
- lcd_timeout  out  1  sticky flag: the last write's busy poll hit POLL_MAX
- LCD_E  out  1  LCD enable strobe
- LCD_RS  out  1  LCD register select
- LCD_RW  out  1  LCD read/not-write
- LCD_data  inout  8  LCD data bus, tri-stated unless this block is writing

## Operation
- States: IDLE, SETUP, ENABLE, HOLD, RECOVER, ACK. One down-counter is loaded on each state entry.
- waitrequest = (read | write) & ~ack. ack is a registered one-cycle pulse that is high only in ACK.
- IDLE: when read or write is seen, latch address, writedata and op. If both are high, write wins.
- Mismatched access (write with address[0]=1, or read with address[0]=0): go straight to ACK. No LCD cycle occurs and readdata=0x00.
- Matched access: go to SETUP. LCD_RS = latched address[1], LCD_RW = latched address[0].
- LCD_data is driven with the latched writedata during SETUP, ENABLE and HOLD of write cycles only. It is high-Z at all other times.
- ENABLE: LCD_E=1. On read cycles, LCD_data is sampled into readdata on the last ENABLE cycle.
- HOLD then RECOVER, both with LCD_E=0.
- Write with BUSY_POLL=1:
  - After RECOVER, run status-read cycles (RS=0, RW=1) through the same SETUP..RECOVER sequence.
  - Exit to ACK when sampled DB7=0.
  - If POLL_MAX reads all return DB7=1, go to ACK and set lcd_timeout.
  - readdata in the ack cycle = last status byte read.
- Write with BUSY_POLL=0, and all reads: go from RECOVER to ACK. Reads never poll.
- lcd_timeout clears at the start of the next matched write.
- ACK returns to IDLE. A new request is accepted no earlier than the cycle after ACK.

## Timing
Cycle 0 = first cycle with read or write high while in IDLE.
- Plain access with defaults:
  - SETUP: cycles 1–3
  - ENABLE: cycles 4–15
  - HOLD: cycle 16
  - RECOVER: cycles 17–25
  - ACK: cycle 26, so waitrequest is low in cycle 26 only
- General latency: ACK at cycle 1+T_AS+T_EH+T_AH+T_REC.
- Each poll adds T_AS+T_EH+T_AH+T_REC cycles (25 with defaults).
- Mismatched access: ACK at cycle 1.
- Reset values: LCD_E=0, LCD_RS=0, LCD_RW=1, LCD_data=Z, readdata=0x00, lcd_timeout=0, ack=0, state=IDLE.
- Reset asserted mid-operation (any state):
  - LCD_E drops and LCD_data tri-states asynchronously.
  - No ack is issued for the interrupted transfer.
  - The master must reissue it.
- Poll counter width is ceil(log2(POLL_MAX+1)). It must not wrap.
- Any dropping of read/write by the master before ack is a protocol violation. The block finishes the cycle regardless.

## Test plan
- BUSY_POLL=0, write address=2'b10, data=0x41:
  - RS=1, RW=0, LCD_data=0x41 from cycle 1 to 16.
  - LCD_E high in cycles 4–15.
  - waitrequest low only in cycle 26.
- Read address=2'b01, LCD model drives 0x80: LCD_E high in cycles 4–15, readdata=0x80 in the ack cycle (26), LCD_data never driven by the DUT.
- BUSY_POLL=1, write 0x01 to address 0, model reports DB7=1 for 2 polls then 0x00:
  - 3 status reads.
  - ack at cycle 26+3×25=101.
  - readdata=0x00, lcd_timeout=0.
- BUSY_POLL=1, POLL_MAX=4, model always returns 0x80: exactly 4 status reads, ack, then lcd_timeout=1. The next matched write clears it.
- Write with address=2'b01: ack in cycle 1, LCD_E never rises, readdata=0x00.
- Assert reset during ENABLE of a write:
  - LCD_E=0 and LCD_data=Z in the same cycle.
  - No ack.
  - After release, a fresh write completes with the nominal 27-cycle timing.
